// File: rtl/pc_next_unit.sv
// Program counter sequencer: fetch handshake FSM and next-PC selection.
// Ports: clk/reset, stall, branch_taken/branch_offset, jump/jump_index,
//   imem_ack in; pc, pc_plus4, imem_req, fetch_valid, redirect_count out.
//   Macro PC_REDIRECT_COUNT_EN enables the saturating redirect counter.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic        r_fetch_valid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_load_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_load_pc  = (r_state == UPDATE) && !stall;

    // Jump wins over branch; branch target wraps modulo 2^32.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (jump)
            w_pc_next = {w_pc_plus4[31:28], jump_index, 2'b00};
        else if (branch_taken)
            w_pc_next = w_pc_plus4 + branch_offset;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (imem_ack) w_state_next = UPDATE;
            UPDATE:  if (!stall) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    // imem_req is registered from the next state so it is high
    // exactly while the FSM sits in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_imem_req    <= (w_state_next == FETCH);
            r_fetch_valid <= (r_state == FETCH) && imem_ack;
            if (w_load_pc)
                r_pc <= w_pc_next;
        end
    end

`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] r_redirect_count;
    logic        w_redirect;

    assign w_redirect = w_load_pc && (jump || branch_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_redirect_count <= 16'h0000;
        else if (w_redirect && (r_redirect_count != 16'hFFFF))
            r_redirect_count <= r_redirect_count + 16'd1;
    end

    assign redirect_count = r_redirect_count;
`else
    assign redirect_count = 16'h0000;
`endif

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign imem_req    = r_imem_req;
    assign fetch_valid = r_fetch_valid;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with an expected-PC scoreboard.
// Expected fetch addresses are queued at each PC update and popped per fetch.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        fetch_valid;
    logic [15:0] redirect_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];
    logic [31:0] cur_pc = 32'h0;
    logic [15:0] exp_cnt = 16'h0;

    pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_index     (jump_index),
        .imem_ack       (imem_ack),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .imem_req       (imem_req),
        .fetch_valid    (fetch_valid),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] p,
                                          input logic j, input logic b,
                                          input logic [31:0] off,
                                          input logic [25:0] idx);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j) return {p4[31:28], idx, 2'b00};
        if (b) return p4 + off;
        return p4;
    endfunction

    task automatic fetch();
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", {31'b0, imem_req}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            cur_pc = sb.pop_front();
            check("pc", pc, cur_pc);
            check("pc_plus4", pc_plus4, cur_pc + 32'd4);
        end
        @(negedge clk);
        check("req_hold", {31'b0, imem_req}, 32'd1);
        check("pc_hold_fetch", pc, cur_pc);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("fv_pulse", {31'b0, fetch_valid}, 32'd1);
        check("req_drop", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic update(input int nstall, input logic j, input logic b,
                          input logic [31:0] off, input logic [25:0] idx);
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1;
            imem_ack = 1'b1;
            jump = 1'b1;
            branch_taken = 1'b1;
            branch_offset = 32'hDEAD_BEEF;
            jump_index = 26'h3FF_FFFF;
            @(negedge clk);
            check("stall_fv", {31'b0, fetch_valid}, 32'd0);
            check("stall_pc", pc, cur_pc);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        imem_ack = 1'b0;
        jump = j;
        branch_taken = b;
        branch_offset = off;
        jump_index = idx;
        sb.push_back(model(cur_pc, j, b, off, idx));
`ifdef PC_REDIRECT_COUNT_EN
        if ((j || b) && exp_cnt != 16'hFFFF) exp_cnt++;
`endif
        @(negedge clk);
        jump = 1'b0;
        branch_taken = 1'b0;
        branch_offset = 32'h0;
        jump_index = 26'h0;
        check("upd_fv", {31'b0, fetch_valid}, 32'd0);
        check("redir_cnt", {16'b0, redirect_count}, {16'b0, exp_cnt});
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_fv", {31'b0, fetch_valid}, 32'd0);
        check("rst_cnt", {16'b0, redirect_count}, 32'd0);
        reset = 1'b0;
        sb.push_back(32'h0);
        @(negedge clk);
        check("idle_to_fetch", {31'b0, imem_req}, 32'd1);

        fetch();
        update(0, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch();
        update(0, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch();
        check("seq_pc8", pc, 32'h0000_0008);
        update(0, 1'b0, 1'b1, 32'h0000_00F4, 26'h0);
        fetch();
        check("pc_100", pc, 32'h0000_0100);
        update(0, 1'b0, 1'b1, 32'hFFFF_FFF0, 26'h0);
        fetch();
        check("neg_branch", pc, 32'h0000_00F4);
        update(0, 1'b0, 1'b1, 32'h3FFF_FF08, 26'h0);
        fetch();
        check("pc_4000", pc, 32'h4000_0000);
        update(0, 1'b1, 1'b1, 32'h0000_1234, 26'h0000010);
        fetch();
        check("jump_prio", pc, 32'h4000_0040);
        update(3, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch();
        check("after_stall", pc, 32'h4000_0044);
        update(0, 1'b0, 1'b1, 32'hBFFF_FFB4, 26'h0);
        fetch();
        check("pc_top", pc, 32'hFFFF_FFFC);
        check("plus4_wrap", pc_plus4, 32'h0000_0000);
        update(0, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch();
        check("pc_wrapped", pc, 32'h0000_0000);
        update(0, 1'b0, 1'b0, 32'h0, 26'h0);

        check("pre_rst_req", {31'b0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_pc", pc, 32'h0);
        check("arst_fv", {31'b0, fetch_valid}, 32'd0);
        check("arst_cnt", {16'b0, redirect_count}, 32'd0);
        @(negedge clk);
        check("rst_hold_req", {31'b0, imem_req}, 32'd0);
        exp_cnt = 16'h0;
        sb.delete();
        sb.push_back(32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("restart_req", {31'b0, imem_req}, 32'd1);
        fetch();
        update(0, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch();
        check("restart_pc4", pc, 32'h0000_0004);
        update(0, 1'b1, 1'b0, 32'h0, 26'h0000100);
        fetch();
        check("jump_only", pc, 32'h0000_0400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, which holds the PC in UPDATE when high.
REQ-005 SHALL have port branch_taken, input, 1, selecting the branch target.
REQ-006 SHALL have port branch_offset, input, 32, a byte offset already shifted left by 2 (word-aligned).
REQ-007 SHALL have port jump, input, 1, selecting the jump target.
REQ-008 SHALL have port jump_index, input, 26, the J-type instruction index field.
REQ-009 SHALL have port imem_ack, input, 1, instruction memory acknowledge.
REQ-010 SHALL have port pc, output, 32, the registered current fetch address.
REQ-011 SHALL have port pc_plus4, output, 32, equal to pc + 4 (combinational).
REQ-012 SHALL have port imem_req, output, 1, the registered fetch request.
REQ-013 SHALL have port fetch_valid, output, 1, a one-cycle pulse marking a completed fetch.
REQ-014 SHALL have port redirect_count, output, 16, the count of taken redirects (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FETCH and UPDATE.
REQ-016 SHALL transition IDLE->FETCH unconditionally one cycle after reset release.
REQ-017 SHALL drive imem_req=1 exactly while in FETCH; pc SHALL stay constant in FETCH.
REQ-018 SHALL transition FETCH->UPDATE on imem_ack=1 and assert fetch_valid=1 for exactly the first cycle in UPDATE.
REQ-019 SHALL ignore imem_ack in IDLE and UPDATE.
REQ-020 SHALL, in UPDATE with stall=1, hold pc and state; fetch_valid SHALL NOT re-pulse.
REQ-021 SHALL, in UPDATE with stall=0, load pc<=next_pc and go to FETCH in the same edge.
REQ-022 SHALL select next_pc by priority: jump > branch_taken > pc_plus4.
REQ-023 SHALL compute branch target = pc_plus4 + branch_offset, modulo 2^32 (wrap, no overflow flag).
REQ-024 SHALL compute jump target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-025 SHALL sample jump, branch_taken, branch_offset and jump_index only on the UPDATE, stall=0 edge.
REQ-026 SHALL compute pc_plus4 with wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-027 SHALL, while reset=1, force pc=RESET_PC, imem_req=0, fetch_valid=0, redirect_count=0 and state=IDLE, independent of clk.
REQ-028 SHALL, on reset asserted mid-FETCH, drop imem_req immediately (same cycle, asynchronous).

Configuration
REQ-029 SHALL compile the redirect counter only when macro PC_REDIRECT_COUNT_EN is defined.
REQ-030 SHALL, with PC_REDIRECT_COUNT_EN defined, increment redirect_count on each UPDATE, stall=0 edge where jump or branch_taken is 1, saturating at 16'hFFFF.
REQ-031 SHALL, without PC_REDIRECT_COUNT_EN, tie redirect_count to 16'h0000 and contain no counter logic.

Verification
REQ-032 Reset release, RESET_PC=0, imem_ack returned 1 cycle after req, no branch/jump -> pc sequence 0,4,8; fetch_valid pulses once per fetch.
REQ-033 pc=32'h0000_0100, branch_taken=1, branch_offset=32'hFFFF_FFF0 -> next pc=32'h0000_00F4.
REQ-034 pc=32'h4000_0000, jump=1 and branch_taken=1 together, jump_index=26'h0000010 -> next pc=32'h4000_0040.
REQ-035 stall=1 for 3 UPDATE cycles, then stall=0 -> pc held 3 cycles; single fetch_valid pulse; then pc advances by 4.
REQ-036 reset asserted while imem_req=1 -> imem_req=0 and pc=RESET_PC before the next clk edge; FSM restarts in IDLE.
REQ-037 With PC_REDIRECT_COUNT_EN: 3 taken branches + 1 jump -> redirect_count=4; without the macro -> redirect_count stays 0.
